// File: rtl/filt_ctrl.sv
// Sequencer in front of the filter datapath: buffers ADC samples in a FIFO, runs one
// start/done transaction per sample and hands each result downstream on valid/ready.
module filt_ctrl #(
    parameter int DATA_W  = 16,
    parameter int FIFO_AW = 3,
    parameter int START_W = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              smp_ready,
    input  logic [1:0]        sel_req,
    input  logic              sel_req_valid,
    output logic              filt_start,
    output logic [1:0]        filt_select,
    output logic [DATA_W-1:0] input_val,
    input  logic [DATA_W-1:0] filt_result,
    input  logic              filt_done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    input  logic              out_ready,
    output logic              busy,
    output logic              ovf_err,
    output logic              tmo_err
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int SCNT_W = (START_W > 1) ? $clog2(START_W) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [FIFO_AW:0]   FULL_CNT   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [SCNT_W-1:0]  START_LAST = SCNT_W'(START_W - 1);
    localparam logic [WCNT_W-1:0]  WAIT_LAST  = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t              state_q, state_d;

    logic [DATA_W-1:0]   fifo_mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                smp_ready_q, smp_ready_d;

    logic                pend_valid_q, pend_valid_d;
    logic [1:0]          pend_sel_q, pend_sel_d;
    logic [1:0]          filt_select_q, filt_select_d;

    logic [DATA_W-1:0]   input_val_q, input_val_d;
    logic [SCNT_W-1:0]   start_cnt_q, start_cnt_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                filt_start_q, filt_start_d;
    logic                filt_done_q, filt_done_d;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [1:0]          out_sel_q, out_sel_d;

    logic                busy_q, busy_d;
    logic                ovf_err_q, ovf_err_d;
    logic                tmo_err_q, tmo_err_d;

    logic                push;
    logic                pop;
    logic                done_rise;

    assign push      = smp_valid && smp_ready_q;
    assign done_rise = filt_done && !filt_done_q;

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_sel_d    = pend_sel_q;
        filt_select_d = filt_select_q;
        input_val_d   = input_val_q;
        start_cnt_d   = start_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sel_d     = out_sel_q;
        tmo_err_d     = tmo_err_q;
        ovf_err_d     = ovf_err_q;

        case (state_q)
            S_IDLE: begin
                // A waiting select change goes first so the next sample sees it.
                if (pend_valid_q) begin
                    filt_select_d = pend_sel_q;
                    pend_valid_d  = 1'b0;
                end else if (count_q != '0) begin
                    pop         = 1'b1;
                    input_val_d = fifo_mem[rd_ptr_q];
                    start_cnt_d = '0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (start_cnt_q == START_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    start_cnt_d = start_cnt_q + SCNT_W'(1);
                end
            end
            S_WAIT: begin
                // A result on the final wait cycle still counts as a completion.
                if (done_rise) begin
                    out_data_d  = filt_result;
                    out_sel_d   = filt_select_q;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    tmo_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh request lands after any apply above, so the newest one is kept.
        if (sel_req_valid && (sel_req != 2'b11)) begin
            pend_valid_d = 1'b1;
            pend_sel_d   = sel_req;
        end

        if (smp_valid && !smp_ready_q) begin
            ovf_err_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
        smp_ready_d  = (count_d != FULL_CNT);
        filt_start_d = (state_d == S_START);
        busy_d       = (state_d != S_IDLE) || (count_d != '0);
        filt_done_d  = filt_done;
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= smp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            smp_ready_q   <= 1'b1;
            pend_valid_q  <= 1'b0;
            pend_sel_q    <= 2'b00;
            filt_select_q <= 2'b00;
            input_val_q   <= '0;
            start_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            filt_start_q  <= 1'b0;
            filt_done_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sel_q     <= 2'b00;
            busy_q        <= 1'b0;
            ovf_err_q     <= 1'b0;
            tmo_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            smp_ready_q   <= smp_ready_d;
            pend_valid_q  <= pend_valid_d;
            pend_sel_q    <= pend_sel_d;
            filt_select_q <= filt_select_d;
            input_val_q   <= input_val_d;
            start_cnt_q   <= start_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            filt_start_q  <= filt_start_d;
            filt_done_q   <= filt_done_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sel_q     <= out_sel_d;
            busy_q        <= busy_d;
            ovf_err_q     <= ovf_err_d;
            tmo_err_q     <= tmo_err_d;
        end
    end

    assign smp_ready   = smp_ready_q;
    assign filt_start  = filt_start_q;
    assign filt_select = filt_select_q;
    assign input_val   = input_val_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sel     = out_sel_q;
    assign busy        = busy_q;
    assign ovf_err     = ovf_err_q;
    assign tmo_err     = tmo_err_q;

endmodule
